// File: rtl/uart_json_tx_if.sv
// ----------------------------------------------------------------------------
// uart_json_tx_if
// Byte handshake between the command translator (producer) and the UART JSON
// transmitter (consumer). A byte moves on a clock edge where both
// byte_valid and byte_ready are high.
//
//   byte_in     producer -> consumer  8-bit ASCII byte
//   byte_valid  producer -> consumer  byte_in is valid this cycle
//   byte_ready  consumer -> producer  consumer can accept a byte
// ----------------------------------------------------------------------------
interface uart_json_tx_if;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       byte_ready;

  modport master (output byte_in, output byte_valid, input  byte_ready);
  modport slave  (input  byte_in, input  byte_valid, output byte_ready);
endinterface

// File: rtl/uart_json_tx.sv
// ----------------------------------------------------------------------------
// uart_json_tx
// Buffers the ASCII JSON bytes produced by the command translator in a byte
// FIFO and serialises them as UART 8N1 (LSB first) to the motor controller.
// Frames are sent back-to-back, with no idle gap, while the FIFO holds data.
//
// Parameters
//   CLKS_PER_BIT  clk cycles per UART bit (>= 2)
//   FIFO_DEPTH    FIFO entries (power of 2)
//
// Ports
//   clk         system clock, rising edge
//   reset       synchronous, active-high; aborts any frame and flushes FIFO
//   in_if       slave side of the byte handshake (byte_in/valid/ready)
//   tx          UART serial line, registered, idle high
//   busy        FIFO non-empty or a frame in progress
//   fifo_count  bytes stored in the FIFO (excludes the byte being sent)
// ----------------------------------------------------------------------------
module uart_json_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  uart_json_tx_if.slave               in_if,
  output logic                        tx,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [BW-1:0] BAUD_LAST  = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  // --------------------------------------------------------------------------
  // Byte FIFO
  // --------------------------------------------------------------------------
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  assign full  = (count == FULL_COUNT);
  assign empty = (count == '0);

  // Ready looks only at the stored count, not at a pop on the same edge, so
  // a producer stalled on a full FIFO is accepted the cycle after a pop.
  assign in_if.byte_ready = !reset && !full;
  assign push             = in_if.byte_valid && in_if.byte_ready;

  // NOTE: the storage array has no reset; pointers and count alone decide
  // which entries are valid, so clearing it would only cost flops.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_if.byte_in;
    end
  end

  // NOTE: every sequential process uses non-blocking assignments so that all
  // registers update together from the values present before the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // Power-of-2 depth: pointers wrap naturally.
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Serialiser FSM
  // --------------------------------------------------------------------------
  state_t        state,     state_n;
  logic [BW-1:0] baud_cnt,  baud_cnt_n;
  logic [2:0]    bit_idx,   bit_idx_n;
  logic [7:0]    shift_reg, shift_reg_n;
  logic          tx_q,      tx_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      tx_q      <= 1'b1;
    end else begin
      state     <= state_n;
      baud_cnt  <= baud_cnt_n;
      bit_idx   <= bit_idx_n;
      shift_reg <= shift_reg_n;
      tx_q      <= tx_n;
    end
  end

  // tx_n is the line level for the cycle after the edge, so the registered
  // tx only ever changes at a bit boundary.
  always_comb begin
    // NOTE: every output of this block is defaulted first; any path that
    // leaves one unassigned would otherwise infer a latch.
    state_n     = state;
    baud_cnt_n  = baud_cnt;
    bit_idx_n   = bit_idx;
    shift_reg_n = shift_reg;
    tx_n        = tx_q;
    pop         = 1'b0;

    case (state)
      S_IDLE: begin
        tx_n = 1'b1;
        if (!empty) begin
          pop         = 1'b1;
          shift_reg_n = mem[rd_ptr];
          baud_cnt_n  = '0;
          tx_n        = 1'b0;
          state_n     = S_START;
        end
      end

      S_START: begin
        if (baud_cnt == BAUD_LAST) begin
          baud_cnt_n = '0;
          bit_idx_n  = 3'd0;
          tx_n       = shift_reg[0];
          state_n    = S_DATA;
        end else begin
          baud_cnt_n = baud_cnt + BW'(1);
        end
      end

      S_DATA: begin
        if (baud_cnt == BAUD_LAST) begin
          baud_cnt_n = '0;
          if (bit_idx == 3'd7) begin
            tx_n    = 1'b1;
            state_n = S_STOP;
          end else begin
            bit_idx_n = bit_idx + 3'd1;
            tx_n      = shift_reg[bit_idx + 3'd1];
          end
        end else begin
          baud_cnt_n = baud_cnt + BW'(1);
        end
      end

      S_STOP: begin
        if (baud_cnt == BAUD_LAST) begin
          baud_cnt_n = '0;
          // Chain straight into the next start bit when data is waiting.
          if (!empty) begin
            pop         = 1'b1;
            shift_reg_n = mem[rd_ptr];
            tx_n        = 1'b0;
            state_n     = S_START;
          end else begin
            tx_n    = 1'b1;
            state_n = S_IDLE;
          end
        end else begin
          baud_cnt_n = baud_cnt + BW'(1);
        end
      end

      default: begin
        tx_n    = 1'b1;
        state_n = S_IDLE;
      end
    endcase
  end

  assign tx         = tx_q;
  assign busy       = (state != S_IDLE) || !empty;
  assign fifo_count = count;

endmodule
